// File: rtl/replay_window_rx.sv
// Receive-side anti-replay checker: frames incoming bytes, extracts the sequence field
// and judges each frame against a sliding bitmap window of recently accepted sequences.
module replay_window_rx #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 9,
  parameter int SEQ_POS   = 7,
  parameter int SEQ_BYTES = 2,
  parameter int WINDOW    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          rx_complete,
  input  logic                          frame_sync,
  input  logic                          error_clr,
  output logic                          seq_valid,
  output logic                          seq_accept,
  output logic                          replay_error,
  output logic                          stale_error,
  output logic [SEQ_BYTES*DATA_W-1:0]   last_seq,
  output logic [15:0]                   error_count
);

  localparam int SEQ_W = SEQ_BYTES * DATA_W;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] SEQ_FIRST = CNT_W'(SEQ_POS);
  localparam logic [CNT_W-1:0] SEQ_LAST  = CNT_W'(SEQ_POS + SEQ_BYTES - 1);
  localparam logic [SEQ_W-1:0] WIN       = SEQ_W'(WINDOW);

  generate
    if (SEQ_POS + SEQ_BYTES > FRAME_LEN) begin : g_bad_seq_pos
      $error("replay_window_rx: sequence field extends past the end of the frame");
    end
    if (WINDOW < 1 || longint'(WINDOW) > (longint'(1) << (SEQ_W - 1))) begin : g_bad_window
      $error("replay_window_rx: WINDOW out of range for the sequence width");
    end
  endgenerate

  typedef enum logic {IDLE, VERIFY} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     byteCnt_q, byteCnt_d;
  logic [SEQ_W-1:0]     seqSr_q, seqSr_d;
  logic [WINDOW-1:0]    bitmap_q, bitmap_d;
  logic [SEQ_W-1:0]     lastSeq_q, lastSeq_d;
  logic                 haveSeq_q, haveSeq_d;
  logic                 valid_q, valid_d;
  logic                 accept_q, accept_d;
  logic                 replay_q, replay_d;
  logic                 stale_q, stale_d;
  logic [15:0]          errCnt_q, errCnt_d;

  logic [CNT_W-1:0]     idx;
  logic                 inSeq;
  logic [SEQ_W-1:0]     diff;
  logic [SEQ_W-1:0]     age;
  logic [WINDOW-1:0]    ageMask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      byteCnt_q <= '0;
      seqSr_q   <= '0;
      bitmap_q  <= '0;
      lastSeq_q <= '0;
      haveSeq_q <= 1'b0;
      valid_q   <= 1'b0;
      accept_q  <= 1'b0;
      replay_q  <= 1'b0;
      stale_q   <= 1'b0;
      errCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      byteCnt_q <= byteCnt_d;
      seqSr_q   <= seqSr_d;
      bitmap_q  <= bitmap_d;
      lastSeq_q <= lastSeq_d;
      haveSeq_q <= haveSeq_d;
      valid_q   <= valid_d;
      accept_q  <= accept_d;
      replay_q  <= replay_d;
      stale_q   <= stale_d;
      errCnt_q  <= errCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    byteCnt_d = byteCnt_q;
    seqSr_d   = seqSr_q;
    bitmap_d  = bitmap_q;
    lastSeq_d = lastSeq_q;
    haveSeq_d = haveSeq_q;
    valid_d   = 1'b0;
    accept_d  = 1'b0;
    replay_d  = 1'b0;
    stale_d   = 1'b0;
    errCnt_d  = errCnt_q;

    // A byte arriving together with frame_sync is byte 0 of the new frame.
    idx     = frame_sync ? '0 : byteCnt_q;
    inSeq   = (idx >= SEQ_FIRST) && (idx <= SEQ_LAST);
    diff    = seqSr_q - lastSeq_q;
    age     = lastSeq_q - seqSr_q;
    ageMask = WINDOW'(1) << age;

    if (frame_sync) begin
      byteCnt_d = '0;
      seqSr_d   = '0;
    end
    if (rx_complete) begin
      byteCnt_d = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (inSeq) seqSr_d = SEQ_W'({seqSr_d, data_in});
    end

    case (state_q)
      IDLE: begin
        if (rx_complete && idx == SEQ_LAST) state_d = VERIFY;
      end
      VERIFY: begin
        state_d = IDLE;
        valid_d = 1'b1;
        if (!haveSeq_q) begin
          accept_d  = 1'b1;
          lastSeq_d = seqSr_q;
          bitmap_d  = WINDOW'(1);
          haveSeq_d = 1'b1;
        end else if (diff == '0) begin
          replay_d = 1'b1;
        end else if (!diff[SEQ_W-1]) begin
          // Newer frame: slide the window forward, restarting it on a jump past its depth.
          accept_d  = 1'b1;
          lastSeq_d = seqSr_q;
          bitmap_d  = (diff >= WIN) ? WINDOW'(1) : ((bitmap_q << diff) | WINDOW'(1));
        end else if (age >= WIN) begin
          stale_d = 1'b1;
        end else if (|(bitmap_q & ageMask)) begin
          replay_d = 1'b1;
        end else begin
          accept_d = 1'b1;
          bitmap_d = bitmap_q | ageMask;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counting off the registered pulse lets a clear coincident with it lose to the error.
    if (replay_q || stale_q) begin
      if (error_clr)                errCnt_d = 16'd1;
      else if (errCnt_q != 16'hFFFF) errCnt_d = errCnt_q + 16'd1;
    end else if (error_clr) begin
      errCnt_d = '0;
    end
  end

  assign seq_valid    = valid_q;
  assign seq_accept   = accept_q;
  assign replay_error = replay_q;
  assign stale_error  = stale_q;
  assign last_seq     = lastSeq_q;
  assign error_count  = errCnt_q;

endmodule
